output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Round-robin switch allocator for one router output port. Picks one of the
//  five input ports (N,S,E,W,L) requesting this output and drives the 3-bit
//  select for the downstream 5:1 8-bit output mux. Once granted, the winner
//  holds the output until its tail flit transfers (wormhole). An idle
//  watchdog frees an output whose owner stops requesting.
// PARAMETERS
//  TIMEOUT  15  consecutive BUSY cycles with owner req low before forced release (>=1)
//  CNT_W    4   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1  clock, all logic on rising edge
//  rst_n      in   1  synchronous reset, active-low
//  req        in   5  bit0 N, bit1 S, bit2 E, bit3 W, bit4 L: input holds a flit for this output
//  tail       in   5  per input: current flit is the packet's last (meaningful only while req is set)
//  out_ready  in   1  downstream accepts a flit this cycle
//  grant      out  5  one-hot owner; all-zero when idle
//  sel        out  3  mux ctrl: 000 N, 001 S, 010 E, 011 W, 100 L, 111 idle
//  sel_valid  out  1  high iff a grant is held (state BUSY)
//  xfer       out  1  comb: sel_valid & req[owner] & out_ready (flit moves this cycle)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge): state=IDLE, grant=0, sel=3'b111, sel_valid=0,
//    ptr=4 (first search starts at N), wdog=0. Takes effect at that edge,
//    regardless of state or any packet in progress; the in-flight packet is abandoned.
//  - grant, sel and sel_valid are registered. sel always encodes grant (111 when 0).
//  - IDLE: if req!=0, the winner is the first set bit scanning ptr+1, ptr+2, ... mod 5
//    (wrap 4->0). Next edge: state=BUSY, grant/sel=winner, sel_valid=1, wdog=0.
//    Latency from req to sel_valid: 1 cycle. If req==0, stay IDLE.
//  - BUSY, owner o:
//    * xfer & tail[o]: next edge -> IDLE, grant=0, sel=111, sel_valid=0, ptr=o.
//      One-cycle idle bubble before the next arbitration (no back-to-back re-grant).
//    * xfer & ~tail[o]: stay BUSY, wdog=0.
//    * req[o] & ~out_ready: hold; tail is ignored because no transfer occurred. wdog=0.
//    * ~req[o]: wdog+=1; when wdog reaches TIMEOUT -> IDLE, ptr=o, wdog=0.
//      Release happens on the edge where the count hits TIMEOUT.
//  - Requests from non-owners never affect a held grant.
//  - Single-flit packet (head=tail): granted, transferred once, then released.
//  - grant is always one-hot or zero. sel values 101/110 are never driven.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clks with req=11111 -> grant=0, sel=111,
//    sel_valid=0, xfer=0. Release reset -> next clk grant=00001, sel=000.
//  2 Single L packet: req=10000, out_ready=1, tail on 3rd flit ->
//    sel=100 one clk after req; 3 xfer pulses; sel=111 on the next clk.
//  3 Fairness: req=11111, all single-flit, out_ready=1 -> grant order
//    N,S,E,W,L,N. Each grant lasts 1 clk, separated by 1 idle clk.
//  4 Backpressure: owner E mid-packet, out_ready=0 for 4 clks with tail=1 ->
//    sel stays 010, xfer=0. out_ready=1 -> one xfer, then release.
//  5 Watchdog: owner W drops req -> release on 15th clk. Variant: req returns
//    after 14 clks -> no release, wdog clears.
//  6 Mid-packet reset: owner S, 2 of 4 flits sent, rst_n=0 for 1 clk ->
//    reset values at that edge. Next arbitration starts from N.

Source files
------------

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the five router input ports and one output-port allocator.
// master drives requests; slave is the allocator that returns the grant and mux select.
interface output_port_arbiter_if;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       sel_valid;
    logic       xfer;

    modport master (
        output req, tail, out_ready,
        input  grant, sel, sel_valid, xfer
    );

    modport slave (
        input  req, tail, out_ready,
        output grant, sel, sel_valid, xfer
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole switch allocator for one router output port (inputs N,S,E,W,L).
// The winner keeps the output until its tail flit moves or the idle watchdog expires.
module output_port_arbiter #(
    parameter int TIMEOUT = 15,  // idle BUSY cycles before forced release, >= 1
    parameter int CNT_W   = 4    // 2**CNT_W must exceed TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output_port_arbiter_if.slave port_if
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [2:0] SEL_IDLE = 3'b111;

    state_e           state_q;
    logic [4:0]       grant_q;
    logic [2:0]       sel_q;
    logic             sel_valid_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] wdog_q;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             owner_req;
    logic             owner_tail;
    logic             xfer;

    // grant_q is one-hot, so masking avoids indexing with the idle select code.
    assign owner_req  = |(port_if.req  & grant_q);
    assign owner_tail = |(port_if.tail & grant_q);
    assign xfer       = sel_valid_q & owner_req & port_if.out_ready;

    assign port_if.grant     = grant_q;
    assign port_if.sel       = sel_q;
    assign port_if.sel_valid = sel_valid_q;
    assign port_if.xfer      = xfer;

    // First requester after the last owner, scanning ptr+1 .. ptr+5 modulo 5.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            cand = 3'((int'(ptr_q) + i) % 5);
            if (!win_found && port_if.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 5'b00000;
            sel_q       <= SEL_IDLE;
            sel_valid_q <= 1'b0;
            ptr_q       <= 3'd4;
            wdog_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (win_found) begin
                        state_q     <= BUSY;
                        grant_q     <= 5'(1) << win_idx;
                        sel_q       <= win_idx;
                        sel_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (xfer && owner_tail) begin
                        state_q     <= IDLE;
                        grant_q     <= 5'b00000;
                        sel_q       <= SEL_IDLE;
                        sel_valid_q <= 1'b0;
                        ptr_q       <= sel_q;
                        wdog_q      <= '0;
                    end else if (owner_req) begin
                        // Either a body flit moved or the owner is stalled by backpressure.
                        wdog_q <= '0;
                    end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= IDLE;
                        grant_q     <= 5'b00000;
                        sel_q       <= SEL_IDLE;
                        sel_valid_q <= 1'b0;
                        ptr_q       <= sel_q;
                        wdog_q      <= '0;
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: grant owners come from a scoreboard queue
// filled when stimulus is applied and drained when the DUT raises a grant.
module tb_output_port_arbiter;

    logic clk;
    logic rst_n;
    output_port_arbiter_if bus ();

    output_port_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_if (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_g;
    int         xfers;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] enc(input logic [4:0] g);
        logic [2:0] r;
        r = 3'b111;
        for (int i = 0; i < 5; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    // Advance to the next falling edge; inputs set before this apply at the rising edge in between.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.req = '0; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 5'b11111; bus.tail = '0; bus.out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (bus.grant !== 5'b0 || bus.sel !== 3'b111 || bus.sel_valid !== 1'b0 || bus.xfer !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: grant=%b sel=%b sv=%b xfer=%b, expected 00000 111 0 0",
                     bus.grant, bus.sel, bus.sel_valid, bus.xfer);
        end
        exp_q.push_back(5'b00001);
        rst_n = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== enc(exp_g) || bus.sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%b sel=%b, expected %b %b", bus.grant, bus.sel, exp_g, enc(exp_g));
        end
    endtask

    task automatic test_single_l();
        do_reset();
        exp_q.push_back(5'b10000);
        bus.req = 5'b10000; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== 3'b100 || bus.sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_l_grant: grant=%b sel=%b, expected %b 100", bus.grant, bus.sel, exp_g);
        end
        xfers = 0;
        for (int f = 1; f <= 3; f++) begin
            bus.tail = (f == 3) ? 5'b10000 : 5'b00000;
            #1;
            if (bus.xfer === 1'b1) xfers++;
            tick();
        end
        bus.req = '0; bus.tail = '0;
        n_checks++;
        if (xfers != 3) begin
            n_fail++;
            $display("FAIL single_l_xfers: got %0d pulses, expected 3", xfers);
        end
        n_checks++;
        if (bus.sel !== 3'b111 || bus.sel_valid !== 1'b0 || bus.grant !== 5'b0) begin
            n_fail++;
            $display("FAIL single_l_release: sel=%b sv=%b grant=%b, expected 111 0 00000", bus.sel, bus.sel_valid, bus.grant);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        exp_q.push_back(5'b00001); exp_q.push_back(5'b00010); exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01000); exp_q.push_back(5'b10000); exp_q.push_back(5'b00001);
        bus.req = 5'b11111; bus.tail = 5'b11111; bus.out_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            tick();
            n_checks++;
            exp_g = exp_q.pop_front();
            if (bus.grant !== exp_g || bus.sel !== enc(exp_g) || bus.xfer !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_grant_%0d: grant=%b sel=%b xfer=%b, expected %b %b 1",
                         g, bus.grant, bus.sel, bus.xfer, exp_g, enc(exp_g));
            end
            tick();
            n_checks++;
            if (bus.sel_valid !== 1'b0 || bus.sel !== 3'b111) begin
                n_fail++;
                $display("FAIL fair_bubble_%0d: sv=%b sel=%b, expected 0 111", g, bus.sel_valid, bus.sel);
            end
        end
        bus.req = '0; bus.tail = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_q.push_back(5'b00100);
        bus.req = 5'b00100; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_grant: grant=%b sel=%b, expected %b 010", bus.grant, bus.sel, exp_g);
        end
        tick();
        bus.out_ready = 1'b0; bus.tail = 5'b00100;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (bus.xfer !== 1'b0 || bus.sel !== 3'b010 || bus.sel_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: xfer=%b sel=%b sv=%b, expected 0 010 1", c, bus.xfer, bus.sel, bus.sel_valid);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.xfer !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume_xfer: xfer=%b, expected 1", bus.xfer);
        end
        tick();
        bus.req = '0; bus.tail = '0;
        n_checks++;
        if (bus.sel !== 3'b111 || bus.sel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: sel=%b sv=%b, expected 111 0", bus.sel, bus.sel_valid);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        exp_q.push_back(5'b01000);
        bus.req = 5'b01000; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== 3'b011) begin
            n_fail++;
            $display("FAIL wd_grant: grant=%b sel=%b, expected %b 011", bus.grant, bus.sel, exp_g);
        end
        bus.req = '0;
        for (int c = 1; c <= 14; c++) tick();
        n_checks++;
        if (bus.sel_valid !== 1'b1 || bus.sel !== 3'b011) begin
            n_fail++;
            $display("FAIL wd_early_release: sv=%b sel=%b after 14 idle clks, expected 1 011", bus.sel_valid, bus.sel);
        end
        tick();
        n_checks++;
        if (bus.sel_valid !== 1'b0 || bus.sel !== 3'b111 || bus.grant !== 5'b0) begin
            n_fail++;
            $display("FAIL wd_release: sv=%b sel=%b grant=%b after 15 idle clks, expected 0 111 00000",
                     bus.sel_valid, bus.sel, bus.grant);
        end
        // Pointer now sits on W, so with everyone requesting L wins next.
        exp_q.push_back(5'b10000);
        bus.req = 5'b11111;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== enc(exp_g)) begin
            n_fail++;
            $display("FAIL wd_next_rr: grant=%b sel=%b, expected %b %b", bus.grant, bus.sel, exp_g, enc(exp_g));
        end
        bus.req = '0;
    endtask

    task automatic test_watchdog_clear();
        do_reset();
        exp_q.push_back(5'b01000);
        bus.req = 5'b01000; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g) begin
            n_fail++;
            $display("FAIL wdc_grant: grant=%b, expected %b", bus.grant, exp_g);
        end
        bus.req = '0;
        for (int c = 1; c <= 14; c++) tick();
        bus.req = 5'b01000;
        tick();
        bus.req = '0;
        for (int c = 1; c <= 14; c++) tick();
        n_checks++;
        if (bus.sel_valid !== 1'b1 || bus.grant !== 5'b01000) begin
            n_fail++;
            $display("FAIL wdc_cleared: sv=%b grant=%b, expected 1 01000", bus.sel_valid, bus.grant);
        end
        tick();
        n_checks++;
        if (bus.sel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wdc_release: sv=%b, expected 0", bus.sel_valid);
        end
    endtask

    task automatic test_mid_packet_reset();
        do_reset();
        exp_q.push_back(5'b00010);
        bus.req = 5'b00010; bus.tail = '0; bus.out_ready = 1'b1;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== 3'b001) begin
            n_fail++;
            $display("FAIL mpr_grant: grant=%b sel=%b, expected %b 001", bus.grant, bus.sel, exp_g);
        end
        tick(); tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.grant !== 5'b0 || bus.sel !== 3'b111 || bus.sel_valid !== 1'b0 || bus.xfer !== 1'b0) begin
            n_fail++;
            $display("FAIL mpr_reset: grant=%b sel=%b sv=%b xfer=%b, expected 00000 111 0 0",
                     bus.grant, bus.sel, bus.sel_valid, bus.xfer);
        end
        exp_q.push_back(5'b00001);
        rst_n = 1'b1; bus.req = 5'b11111;
        tick();
        n_checks++;
        exp_g = exp_q.pop_front();
        if (bus.grant !== exp_g || bus.sel !== enc(exp_g)) begin
            n_fail++;
            $display("FAIL mpr_restart: grant=%b sel=%b, expected %b %b", bus.grant, bus.sel, exp_g, enc(exp_g));
        end
        bus.req = '0;
    endtask

    initial begin
        rst_n = 1'b0; bus.req = '0; bus.tail = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_l();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_watchdog_clear();
        test_mid_packet_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
